// File: rtl/pipeline_fwd_unit.sv
// Forwarding and load-use interlock unit for the 5-stage pipeline.
// A shift-register scoreboard tracks in-flight register writes. Each operand port takes its
// data from the youngest in-flight producer, or from the register file when there is none.
// Decode is stalled while that producer is a load whose data has not yet reached a
// forwardable stage.
// Optional build macro: FWD_PERF_CNT_EN adds saturating stall and forward cycle counters.
module pipeline_fwd_unit #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned REG_ADDR_WIDTH = 4,
   parameter int unsigned N_READ         = 2,
   parameter int unsigned FWD_DEPTH      = 3,
   parameter int unsigned LOAD_LAT       = 1
) (
   input  logic                             clk,
   input  logic                             RST,
   input  logic                             issue_valid,
   input  logic                             issue_we,
   input  logic                             issue_is_load,
   input  logic [REG_ADDR_WIDTH-1:0]        issue_rd,
   input  logic                             flush,
   input  logic [N_READ*REG_ADDR_WIDTH-1:0] rs_addr,
   input  logic [N_READ*DATA_WIDTH-1:0]     rs_data_rf,
   input  logic [FWD_DEPTH*DATA_WIDTH-1:0]  stage_data,
   output logic [N_READ*DATA_WIDTH-1:0]     fwd_data,
   output logic [N_READ-1:0]                fwd_hit,
   output logic                             stall
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]                      perf_stall_cnt,
   output logic [31:0]                      perf_fwd_cnt
`endif
);

   // Scoreboard entries: index 0 is the stage right after decode.
   logic [FWD_DEPTH-1:0]      v_q, v_d;
   logic [FWD_DEPTH-1:0]      ld_q, ld_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q [FWD_DEPTH];
   logic [REG_ADDR_WIDTH-1:0] rd_d [FWD_DEPTH];

   // Per-port youngest-match search, forwarding mux and load-use interlock.
   always_comb begin
      logic                      found;
      logic                      usable;
      logic [DATA_WIDTH-1:0]     hit_data;
      logic [REG_ADDR_WIDTH-1:0] addr;
      fwd_data = rs_data_rf;
      fwd_hit  = '0;
      stall    = 1'b0;
      for (int p = 0; p < int'(N_READ); p++) begin
         found    = 1'b0;
         usable   = 1'b0;
         hit_data = '0;
         addr     = rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         // Scan youngest first; the first match shadows any older producer.
         for (int k = 0; k < int'(FWD_DEPTH); k++) begin
            if (!found && v_q[k] && (addr != '0) && (rd_q[k] == addr)) begin
               found    = 1'b1;
               usable   = !ld_q[k] || (k >= int'(LOAD_LAT));
               hit_data = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (found && usable) begin
            fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = hit_data;
            fwd_hit[p]                           = 1'b1;
         end else if (found && issue_valid) begin
            stall = 1'b1;
         end
      end
   end

   // Next scoreboard contents: shift down, insert the issued op or a bubble at entry 0.
   always_comb begin
      v_d[0]  = issue_valid && !stall && !flush && issue_we && (issue_rd != '0);
      ld_d[0] = issue_is_load;
      rd_d[0] = issue_rd;
      for (int k = 1; k < int'(FWD_DEPTH); k++) begin
         // A flush kills the instruction currently in entry 0 before it moves on.
         v_d[k]  = v_q[k-1] && !(flush && (k == 1));
         ld_d[k] = ld_q[k-1];
         rd_d[k] = rd_q[k-1];
      end
   end

   // Scoreboard register with synchronous reset.
   always_ff @(posedge clk) begin
      if (RST) begin
         v_q  <= '0;
         ld_q <= '0;
         for (int k = 0; k < int'(FWD_DEPTH); k++) rd_q[k] <= '0;
      end else begin
         v_q  <= v_d;
         ld_q <= ld_d;
         for (int k = 0; k < int'(FWD_DEPTH); k++) rd_q[k] <= rd_d[k];
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if ((|fwd_hit) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + 32'd1;
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (RST) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_fwd_unit.sv
// Self-checking bench for pipeline_fwd_unit with default parameters.
module tb_pipeline_fwd_unit;

   logic        clk = 1'b0;
   logic        RST;
   logic        issue_valid, issue_we, issue_is_load, flush;
   logic [3:0]  issue_rd;
   logic [7:0]  rs_addr;
   logic [31:0] rs_data_rf;
   logic [47:0] stage_data;
   logic [31:0] fwd_data;
   logic [1:0]  fwd_hit;
   logic        stall;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

   pipeline_fwd_unit dut (
      .clk           (clk),
      .RST           (RST),
      .issue_valid   (issue_valid),
      .issue_we      (issue_we),
      .issue_is_load (issue_is_load),
      .issue_rd      (issue_rd),
      .flush         (flush),
      .rs_addr       (rs_addr),
      .rs_data_rf    (rs_data_rf),
      .stage_data    (stage_data),
      .fwd_data      (fwd_data),
      .fwd_hit       (fwd_hit),
      .stall         (stall)
`ifdef FWD_PERF_CNT_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_fwd_cnt  (perf_fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic [1:0]  hit;
      logic        stall;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [31:0] RF = 32'h0022_0011;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
   task automatic cyc(input string tag, input logic rst, input logic iv, input logic we,
                      input logic ld, input logic [3:0] rd, input logic fl,
                      input logic [7:0] rsa, input logic [31:0] e_data,
                      input logic [1:0] e_hit, input logic e_stall);
      exp_t e;
      RST           = rst;
      issue_valid   = iv;
      issue_we      = we;
      issue_is_load = ld;
      issue_rd      = rd;
      flush         = fl;
      rs_addr       = rsa;
      e.tag = tag; e.data = e_data; e.hit = e_hit; e.stall = e_stall;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check_eq({e.tag, "_data"}, {32'd0, fwd_data}, {32'd0, e.data});
         check_eq({e.tag, "_hit"}, {62'd0, fwd_hit}, {62'd0, e.hit});
         check_eq({e.tag, "_stall"}, {63'd0, stall}, {63'd0, e.stall});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; issue_valid = 0; issue_we = 0; issue_is_load = 0; issue_rd = 0; flush = 0;
      rs_addr = 8'h21; rs_data_rf = RF; stage_data = {16'h2222, 16'h5A5A, 16'hABCD};
      repeat (2) @(posedge clk);
      #1;
      //  tag              rst iv we ld rd     fl rs     data            hit    stall
      cyc("reset_rf",      0, 0, 0, 0, 4'd0,  0, 8'h21, RF,             2'b00, 0);
      cyc("iss_r3",        0, 1, 1, 0, 4'd3,  0, 8'h21, RF,             2'b00, 0);
      cyc("fwd_alu",       0, 1, 0, 0, 4'd0,  0, 8'h23, 32'h0022_ABCD,  2'b01, 0);
      cyc("iss_ld5",       0, 1, 1, 1, 4'd5,  0, 8'h21, RF,             2'b00, 0);
      cyc("ld_use_stall",  0, 1, 0, 0, 4'd0,  0, 8'h51, RF,             2'b00, 1);
      cyc("ld_fwd_k1",     0, 1, 0, 0, 4'd0,  0, 8'h51, 32'h5A5A_0011,  2'b10, 0);
      cyc("iss_alu_r4",    0, 1, 1, 0, 4'd4,  0, 8'h21, RF,             2'b00, 0);
      cyc("iss_ld_r4",     0, 1, 1, 1, 4'd4,  0, 8'h21, RF,             2'b00, 0);
      cyc("young_ld_stl",  0, 1, 0, 0, 4'd0,  0, 8'h24, RF,             2'b00, 1);
      cyc("young_ld_fwd",  0, 1, 0, 0, 4'd0,  0, 8'h24, 32'h0022_5A5A,  2'b01, 0);
      cyc("iss_r0",        0, 1, 1, 0, 4'd0,  0, 8'h21, RF,             2'b00, 0);
      cyc("r0_no_fwd",     0, 1, 0, 0, 4'd0,  0, 8'h00, RF,             2'b00, 0);
      cyc("flush_ld6",     0, 1, 1, 1, 4'd6,  1, 8'h21, RF,             2'b00, 0);
      cyc("flushed_r6",    0, 1, 0, 0, 4'd0,  0, 8'h66, RF,             2'b00, 0);
      cyc("iss_r7",        0, 1, 1, 0, 4'd7,  0, 8'h21, RF,             2'b00, 0);
      cyc("r7_k0",         0, 0, 0, 0, 4'd0,  0, 8'h27, 32'h0022_ABCD,  2'b01, 0);
      cyc("r7_k1",         0, 0, 0, 0, 4'd0,  0, 8'h27, 32'h0022_5A5A,  2'b01, 0);
      cyc("r7_k2",         0, 0, 0, 0, 4'd0,  0, 8'h27, 32'h0022_2222,  2'b01, 0);
      cyc("r7_fell_off",   0, 0, 0, 0, 4'd0,  0, 8'h27, RF,             2'b00, 0);
      cyc("iss_ld8",       0, 1, 1, 1, 4'd8,  0, 8'h21, RF,             2'b00, 0);
      cyc("rst_mid_stall", 1, 1, 0, 0, 4'd0,  0, 8'h28, RF,             2'b00, 1);
      cyc("after_rst",     0, 1, 0, 0, 4'd0,  0, 8'h28, RF,             2'b00, 0);
      cyc("iss_ld9",       0, 1, 1, 1, 4'd9,  0, 8'h21, RF,             2'b00, 0);
      cyc("ld_no_issue",   0, 0, 0, 0, 4'd0,  0, 8'h29, RF,             2'b00, 0);
      cyc("idle",          0, 0, 0, 0, 4'd0,  0, 8'h21, RF,             2'b00, 0);
      for (int i = 0; i < 3; i++) begin
         logic [3:0] r;
         r = 4'(10 + i);
         cyc("pair_ld",    0, 1, 1, 1, r,     0, 8'h21, RF,             2'b00, 0);
         cyc("pair_stall", 0, 1, 0, 0, 4'd0,  0, {4'h2, r}, RF,         2'b00, 1);
         cyc("pair_fwd",   0, 1, 0, 0, 4'd0,  0, {4'h2, r}, 32'h0022_5A5A, 2'b01, 0);
      end
`ifdef FWD_PERF_CNT_EN
      @(negedge clk);
      check_eq("perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd3);
      check_eq("perf_fwd_cnt", {32'd0, perf_fwd_cnt}, 64'd3);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
